// File: rtl/iob_timer_sampler.sv
// -----------------------------------------------------------------------------
// iob_timer_sampler
//   IOb initiator that reads a coherent 64-bit timestamp from an iob_timer.
//   Each client request runs four bus transactions:
//     1. write SAMPLE = 1  (the timer latches its free-running count)
//     2. write SAMPLE = 0
//     3. read  DATA_LOW
//     4. read  DATA_HIGH
//   It then presents {DATA_HIGH, DATA_LOW} on ts_o with a one-cycle
//   ts_valid_o pulse. A watchdog bounds each read-data wait. If the watchdog
//   expires, the block pulses err_o and returns to IDLE without touching ts_o.
//   All bus outputs come straight from flops, so the block can sit directly
//   on an interconnect port.
// -----------------------------------------------------------------------------
module iob_timer_sampler #(
  parameter int                ADDR_W         = 5,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] SAMPLE_ADDR    = 'h8,
  parameter logic [ADDR_W-1:0] DATA_LOW_ADDR  = 'hC,
  parameter logic [ADDR_W-1:0] DATA_HIGH_ADDR = 'h10,
  parameter int                TIMEOUT_W      = 8
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  rst_i,

  // client side
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  output logic [2*DATA_W-1:0]   ts_o,
  output logic                  ts_valid_o,
  output logic                  err_o,

  // IOb manager port
  output logic                  iob_avalid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic                  iob_ready_i,
  input  logic                  iob_rvalid_i,
  input  logic [DATA_W-1:0]     iob_rdata_i
);

  localparam int STRB_W = DATA_W / 8;

  // SAMPLE is a 1-bit field in bit 0 of its byte. The write therefore
  // touches only that byte lane and places the value in the lane's LSB.
  localparam int                LANE        = int'(SAMPLE_ADDR[1:0]);
  localparam logic [STRB_W-1:0] SAMPLE_STRB = STRB_W'(1) << LANE;
  localparam logic [DATA_W-1:0] SAMPLE_ONE  = DATA_W'(1) << (8 * LANE);

  // Watchdog limit: all ones, i.e. 2**TIMEOUT_W-1 cycles without rvalid.
  localparam logic [TIMEOUT_W-1:0] WDOG_LIMIT = {TIMEOUT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,   // waiting for a client request
    ST_S1,     // write SAMPLE=1 outstanding
    ST_S0,     // write SAMPLE=0 outstanding
    ST_RLO_R,  // read DATA_LOW waiting for ready
    ST_RLO_W,  // read DATA_LOW waiting for rvalid
    ST_RHI_R,  // read DATA_HIGH waiting for ready
    ST_RHI_W   // read DATA_HIGH waiting for rvalid
  } state_e;

  state_e                 state_q;
  logic                   avalid_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [STRB_W-1:0]      wstrb_q;
  logic [DATA_W-1:0]      lo_q;
  logic [2*DATA_W-1:0]    ts_q;
  logic                   ts_valid_q;
  logic                   err_q;
  logic [TIMEOUT_W-1:0]   wdog_q;

  logic [TIMEOUT_W-1:0]   wdog_d;
  logic                   wdog_expired;
  logic                   accept;

  // Watchdog next value. Expiry is flagged on the edge where the counter
  // would reach the limit, so a wait lasts at most 2**TIMEOUT_W-1 cycles.
  assign wdog_d       = wdog_q + TIMEOUT_W'(1);
  assign wdog_expired = (wdog_d == WDOG_LIMIT);

  // The subordinate takes the pending request on this edge.
  assign accept = avalid_q & iob_ready_i;

  // Sequencer: walks the four transactions and owns every registered output.
  always_ff @(posedge clk_i) begin
    // NOTE: every flop here uses <= so each branch sees the pre-edge values of
    // all registers; mixing in = would make results depend on statement order.
    if (rst_i) begin
      // NOTE: datapath registers (lo_q, ts_q) are reset as well. ts_o is
      // visible to the client after reset, and any partially captured low
      // word must not survive an abort.
      state_q    <= ST_IDLE;
      avalid_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      lo_q       <= '0;
      ts_q       <= '0;
      ts_valid_q <= 1'b0;
      err_q      <= 1'b0;
      wdog_q     <= '0;
    end else if (cke_i) begin
      // Status outputs are single-cycle pulses unless re-raised below.
      ts_valid_q <= 1'b0;
      err_q      <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            state_q  <= ST_S1;
            avalid_q <= 1'b1;
            addr_q   <= SAMPLE_ADDR;
            wdata_q  <= SAMPLE_ONE;
            wstrb_q  <= SAMPLE_STRB;
          end
        end

        ST_S1: begin
          // Same address and lane; only the written value changes.
          if (accept) begin
            state_q <= ST_S0;
            wdata_q <= '0;
          end
        end

        ST_S0: begin
          if (accept) begin
            state_q <= ST_RLO_R;
            addr_q  <= DATA_LOW_ADDR;
            wdata_q <= '0;
            wstrb_q <= '0;
          end
        end

        ST_RLO_R: begin
          if (accept) begin
            state_q  <= ST_RLO_W;
            avalid_q <= 1'b0;
            wdog_q   <= '0;
          end
        end

        ST_RLO_W: begin
          if (iob_rvalid_i) begin
            state_q  <= ST_RHI_R;
            lo_q     <= iob_rdata_i;
            avalid_q <= 1'b1;
            addr_q   <= DATA_HIGH_ADDR;
          end else if (wdog_expired) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
          end else begin
            wdog_q <= wdog_d;
          end
        end

        ST_RHI_R: begin
          if (accept) begin
            state_q  <= ST_RHI_W;
            avalid_q <= 1'b0;
            wdog_q   <= '0;
          end
        end

        ST_RHI_W: begin
          // Returning to IDLE here raises req_ready_o in the same cycle as
          // the ts_valid_o pulse, which allows back-to-back requests.
          if (iob_rvalid_i) begin
            state_q    <= ST_IDLE;
            ts_q       <= {iob_rdata_i, lo_q};
            ts_valid_q <= 1'b1;
          end else if (wdog_expired) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
          end else begin
            wdog_q <= wdog_d;
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          avalid_q <= 1'b0;
        end
      endcase
    end
  end

  // The client may only hand over a request while the sequencer is idle.
  assign req_ready_o  = (state_q == ST_IDLE);

  assign ts_o         = ts_q;
  assign ts_valid_o   = ts_valid_q;
  assign err_o        = err_q;

  assign iob_avalid_o = avalid_q;
  assign iob_addr_o   = addr_q;
  assign iob_wdata_o  = wdata_q;
  assign iob_wstrb_o  = wstrb_q;

endmodule

// File: tb/tb_iob_timer_sampler.sv
// -----------------------------------------------------------------------------
// tb_iob_timer_sampler
//   Directed bench for iob_timer_sampler. A small IOb subordinate model
//   supplies ready and read data and logs each accepted transaction. The main
//   sequence checks the logged bus traffic, the timestamp values and the cycle
//   distances against hand-computed numbers.
//   Latencies are counted inclusively: from the cycle in which the request
//   handshake happens to the cycle in which the pulse is visible, both ends
//   included.
// -----------------------------------------------------------------------------
module tb_iob_timer_sampler;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic                clk = 1'b0;
  logic                cke;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic [2*DATA_W-1:0] ts;
  logic                ts_valid;
  logic                err;
  logic                avalid;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [STRB_W-1:0]   wstrb;
  logic                ready;
  logic                rvalid;
  logic [DATA_W-1:0]   rdata;

  // Second instance with SAMPLE in byte lane 1.
  logic                req9;
  logic                req_ready9;
  logic [2*DATA_W-1:0] ts9;
  logic                ts_valid9;
  logic                err9;
  logic                avalid9;
  logic [ADDR_W-1:0]   addr9;
  logic [DATA_W-1:0]   wdata9;
  logic [STRB_W-1:0]   wstrb9;
  logic                ready9  = 1'b1;
  logic                rvalid9 = 1'b0;
  logic [DATA_W-1:0]   rdata9  = '0;

  always #5 clk = ~clk;

  iob_timer_sampler u_dut (
    .clk_i        (clk),
    .cke_i        (cke),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .ts_o         (ts),
    .ts_valid_o   (ts_valid),
    .err_o        (err),
    .iob_avalid_o (avalid),
    .iob_addr_o   (addr),
    .iob_wdata_o  (wdata),
    .iob_wstrb_o  (wstrb),
    .iob_ready_i  (ready),
    .iob_rvalid_i (rvalid),
    .iob_rdata_i  (rdata)
  );

  iob_timer_sampler #(.SAMPLE_ADDR(5'h9)) u_dut9 (
    .clk_i        (clk),
    .cke_i        (cke),
    .rst_i        (rst),
    .req_valid_i  (req9),
    .req_ready_o  (req_ready9),
    .ts_o         (ts9),
    .ts_valid_o   (ts_valid9),
    .err_o        (err9),
    .iob_avalid_o (avalid9),
    .iob_addr_o   (addr9),
    .iob_wdata_o  (wdata9),
    .iob_wstrb_o  (wstrb9),
    .iob_ready_i  (ready9),
    .iob_rvalid_i (rvalid9),
    .iob_rdata_i  (rdata9)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Subordinate model and monitor. It runs 1 ns after each falling edge, after
  // the main sequence has updated its inputs for the same cycle.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    int                cyc;
  } txn_t;

  txn_t              txns[$];
  int                req_cyc[$];
  int                ts_cyc[$];
  logic [63:0]       ts_val[$];
  logic              ts_rdy[$];
  int                err_cyc[$];

  int                stall_n     = 0;   // ready held low this many cycles per transaction
  int                rd_delay    = 1;   // rvalid this many enabled cycles after read accept
  bit                withhold_hi = 1'b0;
  logic [DATA_W-1:0] lo_val      = '0;
  logic [DATA_W-1:0] hi_val      = '0;

  initial begin
    int                cyc        = 0;
    int                stall_cnt  = 0;
    int                pend_cnt   = 0;
    logic [DATA_W-1:0] pend_data  = '0;
    bit                acc;
    bit                prev_hold  = 1'b0;
    logic [ADDR_W-1:0] prev_addr  = '0;
    logic [DATA_W-1:0] prev_wdata = '0;
    logic [STRB_W-1:0] prev_wstrb = '0;
    ready  = 1'b0;
    rvalid = 1'b0;
    rdata  = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      // A request not yet accepted must stay up with unchanged payload.
      if (prev_hold)
        check("req_hold", {avalid, addr, wdata, wstrb}, {1'b1, prev_addr, prev_wdata, prev_wstrb});
      if (ts_valid) begin
        ts_cyc.push_back(cyc);
        ts_val.push_back(ts);
        ts_rdy.push_back(req_ready);
      end
      if (err) err_cyc.push_back(cyc);
      if (req_valid && req_ready && cke && !rst) req_cyc.push_back(cyc);

      acc = 1'b0;
      if (cke) begin
        rvalid = 1'b0;
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            rvalid = 1'b1;
            rdata  = pend_data;
          end
        end
        ready = 1'b0;
        if (avalid && !rst) begin
          if (stall_cnt < stall_n) begin
            stall_cnt++;
          end else begin
            ready     = 1'b1;
            acc       = 1'b1;
            stall_cnt = 0;
            txns.push_back('{addr: addr, wdata: wdata, wstrb: wstrb, cyc: cyc});
            if (wstrb == '0 && !(withhold_hi && addr == 5'h10)) begin
              pend_cnt  = rd_delay;
              pend_data = (addr == 5'h0C) ? lo_val : hi_val;
            end
          end
        end
      end else begin
        ready  = 1'b0;
        rvalid = 1'b0;
      end
      prev_hold  = avalid && !acc && !rst;
      prev_addr  = addr;
      prev_wdata = wdata;
      prev_wstrb = wstrb;
    end
  end

  task automatic clear_logs();
    txns.delete();
    req_cyc.delete();
    ts_cyc.delete();
    ts_val.delete();
    ts_rdy.delete();
    err_cyc.delete();
  endtask

  task automatic one_request();
    @(negedge clk);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_ts(input int n, input int budget);
    int k = 0;
    while (ts_cyc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [ADDR_W-1:0] exp_addr [4];
    logic [DATA_W-1:0] exp_wdata[4];
    logic [STRB_W-1:0] exp_wstrb[4];
    int                k;
    exp_addr  = '{5'h08, 5'h08, 5'h0C, 5'h10};
    exp_wdata = '{32'h1, 32'h0, 32'h0, 32'h0};
    exp_wstrb = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};

    cke       = 1'b1;
    rst       = 1'b1;
    req_valid = 1'b0;
    req9      = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_req_ready", req_ready, 1);
    check("rst_avalid", avalid, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", wstrb, 0);
    check("rst_ts", ts, 0);
    check("rst_ts_valid", ts_valid, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // 1: nominal sample
    clear_logs();
    lo_val = 32'hDEADBEEF;
    hi_val = 32'h00000001;
    one_request();
    wait_ts(1, 50);
    repeat (3) @(negedge clk);
    check("t1_pulses", ts_cyc.size(), 1);
    check("t1_txn_count", txns.size(), 4);
    if (txns.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t1_addr%0d", i), txns[i].addr, exp_addr[i]);
        check($sformatf("t1_wdata%0d", i), txns[i].wdata, exp_wdata[i]);
        check($sformatf("t1_wstrb%0d", i), txns[i].wstrb, exp_wstrb[i]);
      end
    end
    if (ts_cyc.size() == 1 && req_cyc.size() == 1) begin
      check("t1_ts_pulse", ts_val[0], 64'h00000001_DEADBEEF);
      check("t1_ready_at_pulse", ts_rdy[0], 1);
      check("t1_latency", ts_cyc[0] - req_cyc[0] + 1, 8);
    end
    check("t1_ts_held", ts, 64'h00000001_DEADBEEF);
    check("t1_no_err", err_cyc.size(), 0);

    // 2: subordinate stalls 3 cycles per transaction
    clear_logs();
    stall_n = 3;
    one_request();
    wait_ts(1, 100);
    repeat (3) @(negedge clk);
    check("t2_pulses", ts_cyc.size(), 1);
    check("t2_txn_count", txns.size(), 4);
    if (ts_cyc.size() == 1 && req_cyc.size() == 1) begin
      check("t2_ts", ts_val[0], 64'h00000001_DEADBEEF);
      check("t2_latency", ts_cyc[0] - req_cyc[0] + 1, 20);
    end
    stall_n = 0;

    // 3: DATA_HIGH read never answered -> watchdog error
    clear_logs();
    lo_val      = 32'h12345678;
    withhold_hi = 1'b1;
    one_request();
    k = 0;
    while (err_cyc.size() < 1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("t3_err_pulses", err_cyc.size(), 1);
    check("t3_no_ts_valid", ts_cyc.size(), 0);
    // 255 cycles waiting in RHI_W, pulse visible the cycle after.
    if (err_cyc.size() == 1 && txns.size() == 4)
      check("t3_timeout_dist", err_cyc[0] - txns[3].cyc, 256);
    check("t3_ts_unchanged", ts, 64'h00000001_DEADBEEF);
    check("t3_req_ready", req_ready, 1);
    check("t3_err_low", err, 0);
    withhold_hi = 1'b0;

    // 4: reset while waiting for DATA_LOW, late rvalid arrives after reset
    clear_logs();
    lo_val   = 32'hAAAA5555;
    rd_delay = 5;
    one_request();
    k = 0;
    while (txns.size() < 3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t4_reached_rlo_w", txns.size(), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_ts_zero", ts, 0);
    check("t4_no_ts_valid", ts_cyc.size(), 0);
    check("t4_no_err", err_cyc.size(), 0);
    check("t4_avalid", avalid, 0);
    check("t4_addr", addr, 0);
    check("t4_req_ready", req_ready, 1);
    check("t4_no_new_txn", txns.size(), 3);
    rd_delay = 1;

    // 5: three back-to-back requests, cke low 5 cycles during the second
    clear_logs();
    lo_val    = 32'hFFFFFFFF;
    hi_val    = 32'h00000007;
    @(negedge clk);
    req_valid = 1'b1;
    k = 0;
    while (ts_cyc.size() < 1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    cke = 1'b0;
    repeat (5) @(negedge clk);
    cke = 1'b1;
    k = 0;
    while (req_cyc.size() < 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    req_valid = 1'b0;
    wait_ts(3, 100);
    repeat (3) @(negedge clk);
    check("t5_requests", req_cyc.size(), 3);
    check("t5_pulses", ts_cyc.size(), 3);
    if (ts_cyc.size() == 3 && req_cyc.size() == 3) begin
      check("t5_latency0", ts_cyc[0] - req_cyc[0] + 1, 8);
      check("t5_b2b_req1", req_cyc[1], ts_cyc[0]);
      check("t5_b2b_req2", req_cyc[2], ts_cyc[1]);
      check("t5_space_cke", ts_cyc[1] - ts_cyc[0] + 1, 13);
      check("t5_space", ts_cyc[2] - ts_cyc[1] + 1, 8);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("t5_ts%0d", i), ts_val[i], 64'h00000007_FFFFFFFF);
        check($sformatf("t5_ready%0d", i), ts_rdy[i], 1);
      end
    end

    // 6: SAMPLE in byte lane 1
    @(negedge clk);
    req9 = 1'b1;
    @(negedge clk);
    req9 = 1'b0;
    check("t6_avalid", avalid9, 1);
    check("t6_addr_w1", addr9, 5'h09);
    check("t6_wstrb_w1", wstrb9, 4'b0010);
    check("t6_wdata_w1", wdata9, 32'h00000100);
    @(negedge clk);
    check("t6_addr_w0", addr9, 5'h09);
    check("t6_wstrb_w0", wstrb9, 4'b0010);
    check("t6_wdata_w0", wdata9, 32'h00000000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
